// File: rtl/sqrt_output_pack_if.sv
// Result/handshake bundle between the sqrt stage, the pack FIFO and downstream.
interface sqrt_output_pack_if;
    logic              result;
    logic              sign_in;
    logic signed [6:0] exp_in;
    logic [10:0]       mant_in;
    logic              is_nan_in;
    logic              is_pinf_in;
    logic              is_ninf_in;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic              stall;
    logic              overflow;
    logic [3:0]        count;

    // upstream/downstream side (drives results, consumes packed words)
    modport master (
        output result, sign_in, exp_in, mant_in, is_nan_in, is_pinf_in, is_ninf_in, out_ready,
        input  out_valid, out_data, stall, overflow, count
    );

    // pack block side
    modport slave (
        input  result, sign_in, exp_in, mant_in, is_nan_in, is_pinf_in, is_ninf_in, out_ready,
        output out_valid, out_data, stall, overflow, count
    );
endinterface

// File: rtl/sqrt_output_pack.sv
// Packs sqrt results into binary16 and buffers them in a small FIFO.
module sqrt_output_pack #(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    sqrt_output_pack_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    count;
    logic          overflow;
    logic [15:0]   packed_word;
    logic [6:0]    biased;
    logic          full, rd_en, wr_en;

    assign biased = bus.exp_in + 7'sd15;

    // Combinational binary16 packing; NaN wins over +Inf, -Inf already arrives as NaN.
    always_comb begin
        packed_word = {bus.sign_in, 15'h0};
        if (bus.is_nan_in)
            packed_word = {bus.sign_in, 5'h1F, bus.mant_in[9:0] | 10'h200};
        else if (bus.is_pinf_in)
            packed_word = 16'h7C00;
        else if (bus.exp_in == -7'sd15 && bus.mant_in == 11'd0)
            packed_word = {bus.sign_in, 15'h0};
        else if (bus.exp_in > 7'sd15)
            packed_word = {bus.sign_in, 15'h7C00};
        else if (bus.exp_in < -7'sd14 || !bus.mant_in[10])
            packed_word = {bus.sign_in, 15'h0};
        else
            packed_word = {bus.sign_in, biased[4:0], bus.mant_in[9:0]};
    end

    assign full  = (count == 4'(DEPTH));
    assign rd_en = (count != 4'd0) && bus.out_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign wr_en = bus.result && (!full || rd_en);

    // Storage is not reset: out_data is masked by occupancy instead.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= packed_word;
    end

    // Pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= PW'((int'(wr_ptr) + 1) % DEPTH);
            if (rd_en) rd_ptr <= PW'((int'(rd_ptr) + 1) % DEPTH);
            count <= count + 4'(wr_en) - 4'(rd_en);
            if (bus.result && full && !rd_en) overflow <= 1'b1;
        end
    end

    assign bus.out_valid = (count != 4'd0);
    assign bus.out_data  = (count != 4'd0) ? mem[rd_ptr] : 16'h0000;
    assign bus.stall     = full;
    assign bus.overflow  = overflow;
    assign bus.count     = count;
endmodule

// File: tb/tb_sqrt_output_pack.sv
// Randomized + directed bench for sqrt_output_pack against a queue-based model.
module tb_sqrt_output_pack;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sqrt_output_pack_if bus ();
    sqrt_output_pack #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [15:0] q[$];
    logic        ovf_m = 1'b0;

    // one comparison
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // binary16 packing from the value rules
    function automatic logic [15:0] ref_pack(input bit s, input int e, input int m,
                                             input bit nan, input bit pinf);
        int frac;
        frac = m % 1024;
        if (nan)                    return {s, 5'h1F, 10'(frac | 512)};
        if (pinf)                   return 16'h7C00;
        if (e == -15 && m == 0)     return {s, 15'h0};
        if (e > 15)                 return {s, 15'h7C00};
        if (e < -14 || m < 1024)    return {s, 15'h0};
        return {s, 5'(e + 15), 10'(frac)};
    endfunction

    bit cur_s, cur_nan, cur_pinf;
    int cur_e, cur_m;

    task automatic drive(input bit res, input bit s, input int e, input int m,
                         input bit nan, input bit pinf, input bit ninf, input bit rdy);
        bus.result     = res;
        bus.sign_in    = s;
        bus.exp_in     = 7'(e);
        bus.mant_in    = 11'(m);
        bus.is_nan_in  = nan;
        bus.is_pinf_in = pinf;
        bus.is_ninf_in = ninf;
        bus.out_ready  = rdy;
        cur_s = s; cur_e = e; cur_m = m; cur_nan = nan; cur_pinf = pinf;
    endtask

    task automatic check_all();
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("out_data",  32'(bus.out_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk("count",     32'(bus.count),     32'(q.size()));
        chk("stall",     32'(bus.stall),     32'(q.size() == DEPTH));
        chk("overflow",  32'(bus.overflow),  32'(ovf_m));
    endtask

    // advance one clock: model the edge, then check on the falling edge
    task automatic step();
        bit rd, full;
        @(posedge clk);
        rd   = (q.size() != 0) && bus.out_ready;
        full = (q.size() == DEPTH);
        if (rd) void'(q.pop_front());
        if (bus.result) begin
            if (!full || rd) q.push_back(ref_pack(cur_s, cur_e, cur_m, cur_nan, cur_pinf));
            else ovf_m = 1'b1;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        ovf_m = 1'b0;
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        drive(1, 1, 3, 1500, 0, 0, 0, 1);  // noise while in reset must be ignored
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // sqrt(4)
        drive(1, 0, 1, 'h400, 0, 0, 0, 1);
        step();
        chk("sqrt4_data", 32'(bus.out_data), 32'h4000);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        chk("sqrt4_drain", 32'(bus.count), 32'd0);

        // specials
        drive(1, 1, -15, 0, 0, 0, 0, 1);      step(); chk("zero",  32'(bus.out_data), 32'h8000);
        drive(1, 1, 16, 0, 0, 1, 0, 1);       step(); chk("pinf",  32'(bus.out_data), 32'h7C00);
        drive(1, 1, 16, 'h600, 1, 1, 0, 1);   step(); chk("nan",   32'(bus.out_data), 32'hFE00);
        drive(1, 0, 16, 'h400, 0, 0, 0, 1);   step(); chk("sat",   32'(bus.out_data), 32'h7C00);
        drive(1, 0, -20, 'h400, 0, 0, 1, 1);  step(); chk("flush", 32'(bus.out_data), 32'h0000);
        drive(1, 0, 3, 'h3FF, 0, 0, 0, 1);    step(); chk("nohid", 32'(bus.out_data), 32'h0000);
        drive(0, 0, 0, 0, 0, 0, 0, 1);        step();

        // backpressure: three pulses into a 2-deep FIFO
        drive(1, 0, 0, 'h400, 0, 0, 0, 0); step();
        drive(1, 0, 1, 'h400, 0, 0, 0, 0); step();
        drive(1, 0, 2, 'h400, 0, 0, 0, 0); step();
        chk("bp_count", 32'(bus.count), 32'd2);
        chk("bp_stall", 32'(bus.stall), 32'd1);
        chk("bp_ovf",   32'(bus.overflow), 32'd1);
        chk("bp_head",  32'(bus.out_data), 32'h3C00);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("bp_hold",  32'(bus.out_data), 32'h3C00);
        drive(0, 0, 0, 0, 0, 0, 0, 1); step();
        chk("bp_second", 32'(bus.out_data), 32'h4000);
        step();
        chk("bp_empty", 32'(bus.count), 32'd0);

        // full + simultaneous read/write across pointer wrap
        do_reset();
        drive(1, 0, 0, 'h400, 0, 0, 0, 0); step();
        drive(1, 0, 1, 'h400, 0, 0, 0, 0); step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, i + 2, 'h400 + i * 7, 0, 0, 0, 1);
            step();
            chk("rw_count", 32'(bus.count), 32'd2);
            chk("rw_ovf",   32'(bus.overflow), 32'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1); step(); step();

        // asynchronous reset mid-operation
        drive(1, 0, 4, 'h400, 0, 0, 0, 0); step();
        chk("pre_rst_count", 32'(bus.count), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_data",  32'(bus.out_data), 32'h0);
        q.delete();
        ovf_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 'h5A0, 0, 0, 0, 0); step();
        chk("post_rst", 32'(bus.out_data), 32'h3DA0);

        // random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int e, m;
            e = int'($urandom_range(0, 40)) - 20;
            m = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2047))
                                            : int'($urandom_range(1024, 2047));
            if ($urandom_range(0, 9) == 0) begin e = -15; m = 0; end
            drive($urandom_range(0, 1), $urandom_range(0, 1), e, m,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
            step();
            if (i == 750) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sqrt_output_pack.md
SQRT_OUTPUT_PACK -- requirements
Module: sqrt_output_pack

Interface
REQ-001 Parameter: DEPTH, default 2, result FIFO depth in entries; power of two, 2..8.
REQ-002 Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 result  in  1  one-cycle completion pulse from the iterative sqrt stage.
REQ-006 sign_in  in  1  result sign.
REQ-007 exp_in  in  7  signed unbiased exponent; -15 denotes zero, 16 denotes special.
REQ-008 mant_in  in  11  mantissa; bit 10 is the hidden bit.
REQ-009 is_nan_in, is_pinf_in, is_ninf_in  in  1 each  special-value flags.
REQ-010 out_valid  out  1  FIFO head holds a packed word.
REQ-011 out_ready  in  1  downstream accepts the head word.
REQ-012 out_data  out  16  IEEE-754 binary16 word at the FIFO head.
REQ-013 stall  out  1  FIFO full; drives the upstream enable low.
REQ-014 overflow  out  1  sticky flag: a result was dropped.
REQ-015 count  out  4  current FIFO occupancy.

Function
REQ-016 Packing SHALL be combinational from the inputs, then written into the FIFO on the clk edge where result=1.
REQ-017 NaN (is_nan_in=1): pack as {sign_in, 5'h1F, mant_in[9:0] | 10'h200}, so the quiet bit is always set.
REQ-018 +Inf (is_pinf_in=1): pack as 16'h7C00.
REQ-019 NaN beats +Inf when both flags are set.
REQ-020 is_ninf_in is ignored for packing, because the upstream stage already maps -Inf to NaN.
REQ-021 Zero (exp_in = -15 and mant_in = 0): pack as {sign_in, 15'h0}.
REQ-022 Normal numbers: biased exponent = exp_in + 15 computed at 7-bit width; pack as {sign_in, biased[4:0], mant_in[9:0]}.
REQ-023 Normal number with exp_in > 15: saturate to {sign_in, 15'h7C00}.
REQ-024 Normal number with exp_in < -14, or with mant_in[10] = 0: flush to {sign_in, 15'h0}.
REQ-025 FIFO write occurs when result=1 and the FIFO is not full, or when it is full and a read happens in the same cycle.
REQ-026 FIFO read occurs when out_valid=1 and out_ready=1.
REQ-027 Latency: a word written at edge N is visible on out_data with out_valid=1 after edge N when the FIFO was empty; write-through (same-cycle bypass) is not permitted.
REQ-028 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Simultaneous read and write: count unchanged; the read pointer and the write pointer each advance.
REQ-030 Read and write pointers wrap modulo DEPTH.
REQ-031 Full with result=1 and no read: the word is dropped, overflow sets to 1 at the next edge, and FIFO contents are unchanged.
REQ-032 overflow clears only on rst.
REQ-033 stall = (count == DEPTH), registered-derived and glitch-free.
REQ-034 Empty FIFO: out_valid=0; out_data = 16'h0000.

Reset
REQ-035 Asserting rst, including mid-transfer, clears asynchronously: pointers = 0, count = 0, out_valid = 0, out_data = 0, stall = 0, overflow = 0.
REQ-036 Inputs are ignored while rst=1.
REQ-037 The first write is accepted on the first rising edge after rst deasserts.

Verification
REQ-038 sqrt(4) case: result pulse with sign 0, exp 1, mant 0x400, out_ready=1 -> next cycle out_valid=1, out_data=16'h4000; pops the following cycle, count returns to 0.
REQ-039 Specials: zero (sign 1, exp -15, mant 0) -> 16'h8000; is_pinf_in=1 -> 16'h7C00; is_nan_in=1, sign 1, mant 0x600 -> 16'hFE00.
REQ-040 Backpressure: out_ready=0, three result pulses with DEPTH=2 -> count=2, stall=1, overflow=1; the first two words are held in order; raising out_ready drains exactly 2 words.
REQ-041 Full FIFO plus simultaneous read and write -> count stays 2, overflow stays 0, output order is preserved across pointer wrap.
REQ-042 Saturation: exp 16 with no flags -> 16'h7C00; exp -20 -> 16'h0000.
REQ-043 Reset mid-operation: rst asserted with count=1 and out_ready=0 -> out_valid=0 and count=0 immediately; a post-reset pulse with exp 0, mant 0x5A0 -> 16'h3DA0.
